// File: rtl/tdc_event_builder_pkg.sv
// Shared constants, result-word layout and FSM encoding for the TDC event builder.
package tdc_event_builder_pkg;

    localparam int TDC_BINS_PER_CLK = 200;
    localparam int RANGE_ERR_BIT    = 63;
    localparam int UNDERFLOW_BIT    = 62;
    localparam int INTERVAL_W       = 62;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_STOPPED = 3'd2,
        S_MUL     = 3'd3,
        S_SUM     = 3'd4,
        S_PUSH    = 3'd5
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// First-word fall-through synchronous FIFO; writes on full and reads on empty are ignored.
module tdc_sync_fifo #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_wr;
    logic              do_rd;

    // Full/empty come from the level at cycle start, so a pop never frees room for a same-cycle push.
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        level_d  = level_q + LVL_W'(do_wr) - LVL_W'(do_rd);
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/tdc_event_builder.sv
// Collects start/stop fine bins and the coarse count of one measurement, computes the
// interval in delay-line bins and queues the result word for a valid/ready consumer.
module tdc_event_builder
    import tdc_event_builder_pkg::*;
#(
    parameter int BIN_W        = 8,
    parameter int CNT_W        = 48,
    parameter int BINS_PER_CLK = TDC_BINS_PER_CLK,
    parameter int FIFO_DEPTH   = 16,
    parameter int DATA_W       = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_valid,
    input  logic [BIN_W-1:0]              bin_start,
    input  logic                          stop_valid,
    input  logic [BIN_W-1:0]              bin_stop,
    input  logic                          count_done,
    input  logic [CNT_W-1:0]              count,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   abort_cnt,
    output state_e                        dbg_state
);

    // Handshake: the head word transfers on a cycle where m_valid && m_ready; m_data holds until then.
    localparam int PROD_W = CNT_W + 8;
    localparam int SUM_W  = INTERVAL_W + 1;

    state_e                state_q, state_d;
    logic [BIN_W-1:0]      bin_start_q, bin_start_d;
    logic [BIN_W-1:0]      bin_stop_q, bin_stop_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [INTERVAL_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [15:0]           drop_q, drop_d;
    logic [15:0]           abort_q, abort_d;

    logic [PROD_W-1:0]     prod_full;
    logic [SUM_W-1:0]      sum_ext;
    logic [SUM_W-1:0]      stop_ext;
    logic                  underflow;
    logic                  range_err;
    logic [INTERVAL_W-1:0] interval;
    logic                  wr_en;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign prod_full = PROD_W'(count_q) * PROD_W'(BINS_PER_CLK);
    assign sum_ext   = {1'b0, prod_q} + SUM_W'(bin_start_q);
    assign stop_ext  = SUM_W'(bin_stop_q);
    assign underflow = (sum_ext < stop_ext);
    assign interval  = underflow ? '0 : INTERVAL_W'(sum_ext - stop_ext);
    assign range_err = (32'(bin_start_q) >= 32'(BINS_PER_CLK)) ||
                       (32'(bin_stop_q)  >= 32'(BINS_PER_CLK));

    always_comb begin
        state_d     = state_q;
        bin_start_d = bin_start_q;
        bin_stop_d  = bin_stop_q;
        count_d     = count_q;
        prod_d      = prod_q;
        result_d    = result_q;
        drop_d      = drop_q;
        abort_d     = abort_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    bin_start_d = bin_start;
                    state_d     = S_ARMED;
                end
            end
            S_ARMED: begin
                // A stop wins over count_done; a start in the same cycle as a stop is kept.
                if (stop_valid) begin
                    if (start_valid) begin
                        bin_start_d = bin_start;
                    end
                    bin_stop_d = bin_stop;
                    state_d    = S_STOPPED;
                end else if (count_done) begin
                    abort_d = sat_inc(abort_q);
                    state_d = S_IDLE;
                end else if (start_valid) begin
                    bin_start_d = bin_start;
                end
            end
            S_STOPPED: begin
                if (count_done) begin
                    count_d = count;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                prod_d  = INTERVAL_W'(prod_full);
                state_d = S_SUM;
            end
            S_SUM: begin
                result_d                   = '0;
                result_d[RANGE_ERR_BIT]    = range_err;
                result_d[UNDERFLOW_BIT]    = underflow;
                result_d[INTERVAL_W-1:0]   = interval;
                state_d                    = S_PUSH;
            end
            S_PUSH: begin
                if (!fifo_full) begin
                    wr_en = 1'b1;
                end else begin
                    drop_d = sat_inc(drop_q);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bin_start_q <= '0;
            bin_stop_q  <= '0;
            count_q     <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            drop_q      <= '0;
            abort_q     <= '0;
        end else begin
            state_q     <= state_d;
            bin_start_q <= bin_start_d;
            bin_stop_q  <= bin_stop_d;
            count_q     <= count_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
            drop_q      <= drop_d;
            abort_q     <= abort_d;
        end
    end

    tdc_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (result_q),
        .full    (fifo_full),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign m_valid   = !fifo_empty;
    assign drop_cnt  = drop_q;
    assign abort_cnt = abort_q;
    assign dbg_state = state_q;

endmodule
